// File: rtl/press_event_fsm.sv
// press_event_fsm: lockout and single/double press classifier; PRESS_BOUNCE_CNT_EN adds bounce_cnt
`timescale 1ns/1ps
module press_event_fsm #(
    parameter int LOCKOUT_CYC    = 4,
    parameter int DOUBLE_WIN_CYC = 10,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rise_edge,
    output logic             single_press,
    output logic             double_press,
    output logic [CNT_W-1:0] press_cnt,
`ifdef PRESS_BOUNCE_CNT_EN
    output logic [CNT_W-1:0] bounce_cnt,
`endif
    output logic             busy
);
    localparam int MAXC = (LOCKOUT_CYC > DOUBLE_WIN_CYC) ? LOCKOUT_CYC : DOUBLE_WIN_CYC;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] LK = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] WN = TW'(DOUBLE_WIN_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOCK1, WAIT2, LOCK2} state_t;

    state_t        state, nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          accept, ignore, sp_nxt, dp_nxt;

    // next state: timer is loaded with duration-1 on entry, state leaves when it reads 0
    always_comb begin
        nxt     = state;
        tmr_nxt = (tmr == '0) ? '0 : tmr - 1'b1;
        accept  = 1'b0;
        ignore  = 1'b0;
        sp_nxt  = 1'b0;
        dp_nxt  = 1'b0;
        case (state)
            IDLE: if (rise_edge) begin
                accept  = 1'b1;
                nxt     = LOCK1;
                tmr_nxt = LK;
            end
            LOCK1: begin
                ignore = rise_edge;
                if (tmr == '0) begin
                    nxt     = WAIT2;
                    tmr_nxt = WN;
                end
            end
            WAIT2: if (rise_edge) begin
                accept  = 1'b1;
                dp_nxt  = 1'b1;
                nxt     = LOCK2;
                tmr_nxt = LK;
            end else if (tmr == '0) begin
                sp_nxt = 1'b1;
                nxt    = IDLE;
            end
            LOCK2: begin
                ignore = rise_edge;
                if (tmr == '0) nxt = IDLE;
            end
        endcase
    end

    // state, timer, registered pulses and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmr          <= '0;
            single_press <= 1'b0;
            double_press <= 1'b0;
            busy         <= 1'b0;
            press_cnt    <= '0;
`ifdef PRESS_BOUNCE_CNT_EN
            bounce_cnt   <= '0;
`endif
        end else begin
            state        <= nxt;
            tmr          <= tmr_nxt;
            single_press <= sp_nxt;
            double_press <= dp_nxt;
            busy         <= (nxt != IDLE);
            if (accept && press_cnt != '1) press_cnt <= press_cnt + 1'b1;
`ifdef PRESS_BOUNCE_CNT_EN
            if (ignore && bounce_cnt != '1) bounce_cnt <= bounce_cnt + 1'b1;
`endif
        end
    end

`ifndef PRESS_BOUNCE_CNT_EN
    logic unused_ignore;
    assign unused_ignore = ignore;
`endif
endmodule

// File: tb/tb_press_event_fsm.sv
// tb_press_event_fsm: directed cycle-accurate checks of press classification, lockout, reset and saturation
`timescale 1ns/1ps
module tb_press_event_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rise_edge = 1'b0;
    logic       rise2 = 1'b0;
    logic       single_press, double_press, busy;
    logic       single2, double2, busy2;
    logic [7:0] press_cnt;
    logic [1:0] press_cnt2;
`ifdef PRESS_BOUNCE_CNT_EN
    logic [7:0] bounce_cnt;
    logic [1:0] bounce_cnt2;
`endif
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    press_event_fsm #(.LOCKOUT_CYC(4), .DOUBLE_WIN_CYC(10), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rise_edge(rise_edge),
        .single_press(single_press), .double_press(double_press),
        .press_cnt(press_cnt),
`ifdef PRESS_BOUNCE_CNT_EN
        .bounce_cnt(bounce_cnt),
`endif
        .busy(busy));

    press_event_fsm #(.LOCKOUT_CYC(4), .DOUBLE_WIN_CYC(10), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rise_edge(rise2),
        .single_press(single2), .double_press(double2),
        .press_cnt(press_cnt2),
`ifdef PRESS_BOUNCE_CNT_EN
        .bounce_cnt(bounce_cnt2),
`endif
        .busy(busy2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rise_edge = 1'b0;
        rise2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // edges e0..e3 (-1 unused), reset cycle rc, expected single/double cycle, first idle cycle be
    task automatic run(input int e0, e1, e2, e3, rc, sp, dp, be, cnt, bnc);
        do_reset();
        for (int t = 0; t <= 40; t++) begin
            rise_edge = (t == e0 || t == e1 || t == e2 || t == e3);
            rst_n = !(rc >= 0 && (t == rc || t == rc + 1));
            @(negedge clk);
            check($sformatf("single c%0d", t), single_press, t == sp);
            check($sformatf("double c%0d", t), double_press, t == dp);
            check($sformatf("busy c%0d", t), busy, t >= 11 && t < be);
            if (t == rc) check($sformatf("cnt_rst c%0d", t), press_cnt, 0);
            @(posedge clk);
            #1;
        end
        rise_edge = 1'b0;
        check("press_cnt", press_cnt, cnt);
`ifdef PRESS_BOUNCE_CNT_EN
        check("bounce_cnt", bounce_cnt, bnc);
`else
        if (bnc < 0) $display("bad bounce expectation %0d", bnc);
`endif
    endtask

    initial begin
        int nsp, ndp;
        #2;
        check("rst single", single_press, 0);
        check("rst double", double_press, 0);
        check("rst busy", busy, 0);
        check("rst cnt", press_cnt, 0);
        run(10, -1, -1, -1, -1, 25, -1, 25, 1, 0);
        run(10, 18, -1, -1, -1, -1, 19, 23, 2, 0);
        run(10, 12, 14, -1, -1, 25, -1, 25, 1, 2);
        run(10, 12, 14, 15, -1, -1, 16, 20, 2, 2);
        run(10, 24, -1, -1, -1, -1, 25, 29, 2, 0);
        run(10, 11, 12, 13, -1, 25, -1, 25, 1, 3);
        run(10, -1, -1, -1, 17, -1, -1, 17, 0, 0);
        do_reset();
        nsp = 0;
        ndp = 0;
        for (int k = 0; k < 5; k++) begin
            rise2 = 1'b1;
            @(posedge clk);
            #1 rise2 = 1'b0;
            repeat (25) begin
                @(negedge clk);
                nsp += int'(single2);
                ndp += int'(double2);
                @(posedge clk);
                #1;
            end
            check($sformatf("sat cnt %0d", k), press_cnt2, (k < 3) ? k + 1 : 3);
        end
        check("sat singles", nsp, 5);
        check("sat doubles", ndp, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
